// File: rtl/cond_pkg.sv
// cond_pkg: ARM condition encodings, flag indices and the condition-pass decode.
package cond_pkg;
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic fn, fz, fc, fv;
        fn = flags[FLAG_N];
        fz = flags[FLAG_Z];
        fc = flags[FLAG_C];
        fv = flags[FLAG_V];
        case (cond)
            COND_EQ: return fz;
            COND_NE: return !fz;
            COND_CS: return fc;
            COND_CC: return !fc;
            COND_MI: return fn;
            COND_PL: return !fn;
            COND_VS: return fv;
            COND_VC: return !fv;
            COND_HI: return fc && !fz;
            COND_LS: return !fc || fz;
            COND_GE: return fn == fv;
            COND_LT: return fn != fv;
            COND_GT: return !fz && (fn == fv);
            COND_LE: return fz || (fn != fv);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/condition_test.sv
// condition_test: registers NZCV every cycle and qualifies the current cond
// against the flags left by the previous instruction.
module condition_test
    import cond_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic       Z,
    input  logic       C,
    input  logic       N,
    input  logic       V,
    output logic       execute
);
    logic [3:0] flags_q, flags_d;

    assign flags_d = reset ? 4'b0000 : {N, Z, C, V};

    always_ff @(posedge clk) flags_q <= flags_d;

    assign execute = cond_pass(cond, flags_q);
endmodule

// File: tb/tb_condition_test.sv
// tb_condition_test: table-driven and sequence checks of condition_test against
// an independent condition model, with a queue-based scoreboard.
module tb_condition_test;
    typedef struct {
        logic       exp;
        string      name;
    } sb_t;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cond_s = 4'h0;
    logic       N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0;
    logic       execute;

    int errors = 0;
    int checks = 0;
    sb_t sb_q[$];
    vec_t vecs[$];

    condition_test dut (
        .clk(clk), .reset(reset), .cond(cond_s),
        .Z(Z), .C(C), .N(N), .V(V), .execute(execute)
    );

    always #5 clk = ~clk;

    function automatic logic model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return (c == 4'hF) ? 1'b0 : (b ^ c[0]);
    endfunction

    task automatic load(input logic [3:0] f, input logic rst);
        {N, Z, C, V} = f;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [3:0] c, input logic exp, input string name);
        sb_t e, got;
        e.exp = exp;
        e.name = name;
        sb_q.push_back(e);
        cond_s = c;
        #1;
        got = sb_q.pop_front();
        checks++;
        if (execute !== got.exp) begin
            errors++;
            $display("FAIL %s cond=%h execute=%b expected=%b", got.name, c, execute, got.exp);
        end
    endtask

    task automatic add(input logic [3:0] f, input logic [3:0] c, input logic e, input string n);
        vec_t v;
        v.flags = f; v.cond = c; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        add(4'b1000, 4'hA, 1'b0, "ge_n1v0");
        add(4'b1000, 4'hB, 1'b1, "lt_n1v0");
        add(4'b1000, 4'hC, 1'b0, "gt_n1v0");
        add(4'b1000, 4'hD, 1'b1, "le_n1v0");
        add(4'b1001, 4'hA, 1'b1, "ge_n1v1");
        add(4'b1001, 4'hC, 1'b1, "gt_n1v1");
        add(4'b1101, 4'hC, 1'b0, "gt_z1");
        add(4'b1101, 4'hD, 1'b1, "le_z1");
        add(4'b0010, 4'h8, 1'b1, "hi_c1z0");
        add(4'b0010, 4'h9, 1'b0, "ls_c1z0");
        add(4'b0010, 4'h2, 1'b1, "cs_c1z0");
        add(4'b0010, 4'h3, 1'b0, "cc_c1z0");
        add(4'b0110, 4'h8, 1'b0, "hi_c1z1");
        add(4'b0110, 4'h9, 1'b1, "ls_c1z1");

        load(4'b1111, 1'b1);
        reset = 1'b0;
        check(4'h0, 1'b0, "rst_eq");
        check(4'h1, 1'b1, "rst_ne");
        check(4'h4, 1'b0, "rst_mi");
        check(4'hE, 1'b1, "rst_al");

        {N, Z, C, V} = 4'b0100;
        check(4'h0, 1'b0, "lat_eq_before");
        @(posedge clk); #1;
        check(4'h0, 1'b1, "lat_eq_after");
        Z = 1'b0;
        check(4'h0, 1'b1, "lat_eq_hold");
        @(posedge clk); #1;
        check(4'h0, 1'b0, "lat_eq_clear");

        foreach (vecs[i]) begin
            load(vecs[i].flags, 1'b0);
            check(vecs[i].cond, vecs[i].exp, vecs[i].name);
        end

        for (int f = 0; f < 16; f++) begin
            load(f[3:0], 1'b0);
            for (int c = 0; c < 16; c++)
                check(c[3:0], model(c[3:0], f[3:0]), $sformatf("sweep_f%h", f[3:0]));
            check(4'hE, 1'b1, "sweep_al");
            check(4'hF, 1'b0, "sweep_nv");
        end

        load(4'b1111, 1'b0);
        check(4'h4, 1'b1, "mid_mi_loaded");
        load(4'b1111, 1'b1);
        reset = 1'b0;
        check(4'h4, 1'b0, "mid_mi_reset");
        check(4'h0, 1'b0, "mid_eq_reset");
        check(4'h3, 1'b1, "mid_cc_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
